// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between a controller and the multi-cycle ALU.
// start/optype/op/acc_in/reg_in flow controller -> ALU.
// busy/done/out/z/c/n/v flow ALU -> controller.
interface alu_seq_if #(
  parameter int W = 8
);
  logic         start;
  logic         optype;
  logic [3:0]   op;
  logic [W-1:0] acc_in;
  logic [W-1:0] reg_in;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         z;
  logic         c;
  logic         n;
  logic         v;
  modport master (output start, optype, op, acc_in, reg_in, input busy, done, out, z, c, n, v);
  modport slave  (input start, optype, op, acc_in, reg_in, output busy, done, out, z, c, n, v);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU; add/sub/logic/cmp in one cycle, shifts and popcount one bit per cycle.
// Ports: clk, rst (async active-high), bus (alu_seq_if.slave):
//   start/optype/op/acc_in/reg_in request, busy/done status, out + z/c/n/v held results.
module alu_seq #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [3:0] OP_ADD = 4'd2, OP_SUB = 4'd3, OP_SHL = 4'd4, OP_SHR = 4'd5, OP_AND = 4'd6,
                         OP_OR = 4'd7, OP_XOR = 4'd8, OP_POP = 4'd9, OP_CMP = 4'd10;
  state_t       st, st_n;
  logic         nop_q, cy, done_q, z_q, c_q, n_q, v_q;
  logic [3:0]   op_q;
  logic [W-1:0] a, b, res, out_q;
  logic [CW-1:0] cnt, s;
  logic [W:0]   sum, dif;
  logic         cf, vf, upd, multi, accept;
  always_comb begin
    s      = bus.reg_in >= W'(W) ? CW'(W) : bus.reg_in[CW-1:0];
    multi  = !bus.optype && (((bus.op == OP_SHL || bus.op == OP_SHR) && s != '0) || bus.op == OP_POP);
    accept = st == IDLE && bus.start;
    st_n   = st == IDLE ? (bus.start ? (multi ? RUN : FIN) : IDLE) :
             st == RUN  ? (cnt == CW'(1) ? FIN : RUN) : IDLE;
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    res    = op_q == OP_ADD ? sum[W-1:0] :
             op_q == OP_SUB ? dif[W-1:0] :
             op_q == OP_AND ? a & b :
             op_q == OP_OR  ? a | b :
             op_q == OP_XOR ? a ^ b : a;
    cf     = op_q == OP_ADD ? sum[W] :
             op_q == OP_SUB ? dif[W] :
             (op_q == OP_SHL || op_q == OP_SHR) ? cy : 1'b0;
    vf     = op_q == OP_ADD ? (a[W-1] == b[W-1] && sum[W-1] != a[W-1]) :
             op_q == OP_SUB ? (a[W-1] != b[W-1] && dif[W-1] != a[W-1]) : 1'b0;
    upd    = !nop_q && op_q >= OP_ADD && op_q <= OP_CMP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      nop_q  <= 1'b0;
      op_q   <= '0;
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      st     <= st_n;
      done_q <= st == FIN;
      if (accept) begin
        nop_q <= bus.optype;
        op_q  <= bus.op;
        // popcount accumulates into a, so it starts from zero
        a     <= (!bus.optype && bus.op == OP_POP) ? '0 : bus.acc_in;
        b     <= bus.reg_in;
        cnt   <= bus.op == OP_POP ? CW'(W) : s;
        cy    <= 1'b0;
      end else if (st == RUN) begin
        cnt <= cnt - CW'(1);
        a   <= op_q == OP_SHL ? a << 1 : op_q == OP_SHR ? a >> 1 : a + W'(b[0]);
        b   <= b >> 1;
        cy  <= op_q == OP_SHL ? a[W-1] : op_q == OP_SHR ? a[0] : 1'b0;
      end else if (st == FIN && upd) begin
        c_q <= cf;
        v_q <= vf;
        if (op_q == OP_CMP) begin
          z_q <= a == b;
          n_q <= a < b;
        end else begin
          out_q <= res;
          z_q   <= res == '0;
          n_q   <= res[W-1];
        end
      end
    end
  end
  assign bus.busy = st != IDLE;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.z    = z_q;
  assign bus.c    = c_q;
  assign bus.n    = n_q;
  assign bus.v    = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with W=8.
module tb_alu_seq;
  typedef struct {
    logic [7:0] out;
    logic       z, c, n, v;
    int         lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [7:0] m_out = '0;
  logic m_z = 0, m_c = 0, m_n = 0, m_v = 0;
  alu_seq_if #(.W(8)) bus();
  alu_seq #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic ot, input logic [3:0] o, input logic [7:0] a, input logic [7:0] r);
    exp_t e;
    int s;
    logic [8:0] t;
    logic wr;
    e.lat = 1;
    wr = 1'b1;
    s = r > 8 ? 8 : int'(r);
    if (ot) wr = 1'b0;
    else case (o)
      4'd2: begin t = {1'b0, a} + {1'b0, r}; m_out = t[7:0]; m_c = t[8]; m_v = (a[7] == r[7]) && (t[7] != a[7]); end
      4'd3: begin t = {1'b0, a} - {1'b0, r}; m_out = t[7:0]; m_c = t[8]; m_v = (a[7] != r[7]) && (t[7] != a[7]); end
      4'd4: begin m_out = s >= 8 ? 8'h00 : a << s; m_c = s == 0 ? 1'b0 : a[8-s]; m_v = 0; e.lat = s == 0 ? 1 : s + 1; end
      4'd5: begin m_out = s >= 8 ? 8'h00 : a >> s; m_c = s == 0 ? 1'b0 : a[s-1]; m_v = 0; e.lat = s == 0 ? 1 : s + 1; end
      4'd6: begin m_out = a & r; m_c = 0; m_v = 0; end
      4'd7: begin m_out = a | r; m_c = 0; m_v = 0; end
      4'd8: begin m_out = a ^ r; m_c = 0; m_v = 0; end
      4'd9: begin m_out = 8'($countones(r)); m_c = 0; m_v = 0; e.lat = 9; end
      4'd10: begin m_z = a == r; m_n = a < r; m_c = 0; m_v = 0; wr = 1'b0; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_z = m_out == 8'h00;
      m_n = m_out[7];
    end
    e.out = m_out; e.z = m_z; e.c = m_c; e.n = m_n; e.v = m_v;
    return e;
  endfunction
  task automatic launch(input logic ot, input logic [3:0] o, input logic [7:0] a, input logic [7:0] r);
    @(negedge clk);
    bus.start = 1'b1; bus.optype = ot; bus.op = o; bus.acc_in = a; bus.reg_in = r;
    sb.push_back(model(ot, o, a, r));
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.optype = 1'($urandom); bus.op = 4'($urandom);
    bus.acc_in = 8'($urandom); bus.reg_in = 8'($urandom);
  endtask
  task automatic finish_op(input string tag, input bit poke);
    int lat, bc;
    exp_t e;
    lat = 0;
    bc = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bc++;
      if (poke && lat == 3) begin
        bus.start = 1'b1; bus.optype = 1'b0; bus.op = 4'd2; bus.acc_in = 8'h11; bus.reg_in = 8'h22;
      end else bus.start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " done"}, 32'(bus.done), 1);
    check({tag, " sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " out"}, 32'(bus.out), 32'(e.out));
      check({tag, " zcnv"}, {bus.z, bus.c, bus.n, bus.v}, {e.z, e.c, e.n, e.v});
      check({tag, " latency"}, lat, e.lat);
      check({tag, " busy cycles"}, bc, e.lat);
    end
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(bus.done), 0);
  endtask
  initial begin
    int seen;
    bus.start = 1'b0; bus.optype = 1'b0; bus.op = '0; bus.acc_in = '0; bus.reg_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", 32'(bus.out), 0);
    check("reset flags", {bus.z, bus.c, bus.n, bus.v}, 0);
    check("reset busy/done", {bus.busy, bus.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(0, 4'd2, 8'hF0, 8'h20); finish_op("add", 0);
    launch(0, 4'd3, 8'h80, 8'h01); finish_op("sub ovf", 0);
    launch(0, 4'd3, 8'h01, 8'h02); finish_op("sub borrow", 0);
    launch(0, 4'd4, 8'h81, 8'd3);  finish_op("shl 3", 0);
    launch(0, 4'd5, 8'h81, 8'd9);  finish_op("shr 9", 0);
    launch(0, 4'd4, 8'h5A, 8'd0);  finish_op("shl 0", 0);
    launch(0, 4'd9, 8'h33, 8'hB5); finish_op("popcnt", 0);
    launch(0, 4'd10, 8'd3, 8'd7);  finish_op("cmp lt", 0);
    launch(0, 4'd9, 8'h00, 8'hB5); finish_op("popcnt poked", 1);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | int'(bus.done) | int'(bus.busy);
    end
    check("ignored start", seen, 0);
    launch(0, 4'd4, 8'h81, 8'd7);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_out = '0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    check("abort out", 32'(bus.out), 0);
    check("abort flags", {bus.z, bus.c, bus.n, bus.v}, 0);
    check("abort busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | int'(bus.done);
    end
    check("abort no done", seen, 0);
    launch(0, 4'd2, 8'h7F, 8'h01); finish_op("add ovf", 0);
    launch(0, 4'd15, 8'h12, 8'h34); finish_op("undef op", 0);
    launch(1, 4'd2, 8'h12, 8'h34); finish_op("nop", 0);
    launch(0, 4'd10, 8'h44, 8'h44); finish_op("cmp eq", 0);
    launch(0, 4'd10, 8'h45, 8'h44); finish_op("cmp gt", 0);
    for (int i = 0; i < 24; i++) begin
      launch(1'($urandom_range(0, 7) == 0), 4'($urandom), 8'($urandom), 8'($urandom_range(0, 12)));
      finish_op($sformatf("rand%0d", i), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
